ahb_bus_arbiter: RTL
====================

// Module: ahb_bus_arbiter
// PURPOSE
//  Two-master AHB-Lite arbiter/multiplexer placed between masters (M0 = AHB_control_unit, M1 = e.g. DMA/debug)
//  and the single AHB slave port of the AHB-to-APB bridge. Grants the bus round-robin, never splits a
//  fixed-length burst, muxes address phase by current owner and write data by data-phase owner.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  DEF_MST  0   default master parked on the bus when nobody requests (0 or 1)
// PORTS
//  iHCLK          in   1    bus clock
//  iHRESETn       in   1    asynchronous active-low reset
//  iMx_HBUSREQ    in   1    bus request, x = 0,1
//  oMx_HGRANT     out  1    grant, x = 0,1; master owns next address phase when HGRANT && HREADY
//  iMx_HADDR      in   AW   address, x = 0,1
//  iMx_HTRANS     in   2    transfer type, x = 0,1
//  iMx_HWRITE     in   1    write, x = 0,1
//  iMx_HSIZE      in   4    size, x = 0,1
//  iMx_HBURST     in   3    burst type, x = 0,1
//  iMx_HWDATA     in   DW   write data, x = 0,1
//  oHADDR/oHTRANS/oHWRITE/oHSIZE/oHBURST  out  AW/2/1/4/3  to slave, muxed from address-phase owner
//  oHWDATA        out  DW   to slave, muxed from data-phase owner
//  iHREADY        in   1    slave ready (bridge oHREADY)
//  iHRESP         in   2    slave response (bridge oHRESP)
//  oHREADY        out  1    iHREADY fanned to both masters
//  oHMASTER       out  1    current address-phase owner (debug/visibility)
// BEHAVIOUR
//  Reset: owner = data_owner = DEF_MST; oMx_HGRANT = (x==DEF_MST); beat_cnt = 0; locked = 0;
//   oHTRANS follows owner's HTRANS combinationally (masters drive IDLE out of reset).
//  Owner register and grants update only on iHCLK edges with iHREADY = 1; with iHREADY = 0 all hold.
//  data_owner <= owner on every iHREADY = 1 edge (one-cycle lag = AHB data phase).
//  Burst lock, evaluated on accepted beats of owner (iHREADY = 1):
//   NONSEQ + HBURST SINGLE(0) -> locked = 0; INCR(1) -> locked while owner's HBUSREQ = 1;
//   WRAP4/INCR4(2,3) -> beat_cnt = 3; WRAP8/INCR8(4,5) -> 7; WRAP16/INCR16(6,7) -> 15; locked = (beat_cnt != 0).
//   SEQ decrements beat_cnt; at 0 lock releases. BUSY holds count. IDLE clears count and lock.
//  Arbitration (when iHREADY = 1 and not locked): next owner = other master if it requests and
//   (current owner not requesting OR current owner was last granted, i.e. round-robin); else current if
//   requesting; if none requests -> DEF_MST. Grant switch visible on oMx_HGRANT the next cycle;
//   the new master's first address phase follows on the next iHREADY = 1 cycle (one cycle handover).
//  Locked burst: beat that completes count -> arbitration runs in that same iHREADY cycle.
//  Error: iHRESP = 2'b01 with iHREADY = 0 (first error cycle) clears beat_cnt/lock; owner keeps grant
//   until the two-cycle response completes, then normal arbitration.
//  Simultaneous requests from reset: DEF_MST wins first, the other master next.
//  Reset mid-burst: everything returns to reset values asynchronously; no partial state survives.
// STRUCTURE
//  Shared package/header: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST codes, HRESP codes, beat-length
//   function burst_beats(hburst). One sub-module natural: ahb_burst_tracker (beat_cnt + locked flag),
//   instanced once for the address-phase owner; arbiter FSM (states OWN0, OWN1) and muxes stay top-level.
// TESTING
//  1 Reset, no requests -> oM0_HGRANT=1, oM1_HGRANT=0, oHMASTER=0, oHTRANS = M0 IDLE.
//  2 M1 requests alone, M0 idle -> oM1_HGRANT=1 next cycle; M1 NONSEQ 0x4000_0000 appears on oHADDR;
//    its HWDATA on oHWDATA exactly one accepted cycle later.
//  3 M0 INCR4 at 0x4000_0000, M1 requests on beat 2 -> no grant change until 4th beat accepted;
//    M1 granted the cycle after, 4 beats of M0 data all routed correctly.
//  4 Both request continuously, SINGLE transfers -> grants alternate 0,1,0,1; iHREADY held 0 for
//    3 cycles mid-sequence -> grant, oHADDR, oHWDATA frozen.
//  5 M0 INCR8 gets iHRESP=ERROR on beat 3 -> lock released after 2-cycle error; waiting M1 granted next.
//  6 Assert iHRESETn low mid INCR16 -> outputs at reset values immediately, grant back to DEF_MST.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB-Lite encodings and arbiter types for the two-master bus arbiter.
// burst_beats() gives the beat count of a fixed-length burst (1 for SINGLE and INCR).
package ahb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    // Arbiter state = master currently holding HGRANT
    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } arb_state_e;

    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            default:                      burst_beats = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Tracks the remaining beats of the address-phase owner's burst and reports whether the
// bus stays locked to that owner once the beat presented this cycle has been accepted.
module ahb_burst_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
    input  logic       err_first,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hbusreq,
    output logic       lock_after
);
    import ahb_bus_arbiter_pkg::*;

    logic [3:0] cnt_q, cnt_d;
    logic       incr_q, incr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            incr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            incr_q <= incr_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        incr_d = incr_q;
        if (err_first) begin
            cnt_d  = 4'd0;
            incr_d = 1'b0;
        end else if (accept) begin
            case (htrans)
                HTRANS_NONSEQ: begin
                    cnt_d  = 4'(burst_beats(hburst) - 5'd1);
                    incr_d = (hburst == HBURST_INCR);
                end
                HTRANS_SEQ: begin
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                end
                HTRANS_IDLE: begin
                    cnt_d  = 4'd0;
                    incr_d = 1'b0;
                end
                default: ;
            endcase
        end
        // Looking at the post-beat state lets the final beat of a burst re-arbitrate in the same cycle
        lock_after = (cnt_d != 4'd0) || (incr_d && hbusreq);
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-Lite arbiter and multiplexer in front of the AHB-to-APB bridge slave port.
// Round-robin grant, bursts never split, address muxed by owner and write data by data-phase owner.
module ahb_bus_arbiter #(
    parameter int   AW      = 32,
    parameter int   DW      = 32,
    parameter logic DEF_MST = 1'b0
) (
    input  logic          iHCLK,
    input  logic          iHRESETn,
    input  logic          iM0_HBUSREQ,
    output logic          oM0_HGRANT,
    input  logic [AW-1:0] iM0_HADDR,
    input  logic [1:0]    iM0_HTRANS,
    input  logic          iM0_HWRITE,
    input  logic [3:0]    iM0_HSIZE,
    input  logic [2:0]    iM0_HBURST,
    input  logic [DW-1:0] iM0_HWDATA,
    input  logic          iM1_HBUSREQ,
    output logic          oM1_HGRANT,
    input  logic [AW-1:0] iM1_HADDR,
    input  logic [1:0]    iM1_HTRANS,
    input  logic          iM1_HWRITE,
    input  logic [3:0]    iM1_HSIZE,
    input  logic [2:0]    iM1_HBURST,
    input  logic [DW-1:0] iM1_HWDATA,
    output logic [AW-1:0] oHADDR,
    output logic [1:0]    oHTRANS,
    output logic          oHWRITE,
    output logic [3:0]    oHSIZE,
    output logic [2:0]    oHBURST,
    output logic [DW-1:0] oHWDATA,
    input  logic          iHREADY,
    input  logic [1:0]    iHRESP,
    output logic          oHREADY,
    output logic          oHMASTER
);
    import ahb_bus_arbiter_pkg::*;

    localparam arb_state_e DEF_STATE = arb_state_e'(DEF_MST);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       data_owner_q, data_owner_d;

    logic [1:0] own_htrans;
    logic [2:0] own_hburst;
    logic       own_hbusreq;
    logic       err_first;
    logic       lock_after;
    logic       cur, req_cur, req_oth;

    assign own_htrans  = owner_q ? iM1_HTRANS  : iM0_HTRANS;
    assign own_hburst  = owner_q ? iM1_HBURST  : iM0_HBURST;
    assign own_hbusreq = owner_q ? iM1_HBUSREQ : iM0_HBUSREQ;
    // First cycle of the two-cycle ERROR response drops any burst lock
    assign err_first   = (iHRESP == HRESP_ERROR) && !iHREADY;

    ahb_burst_tracker u_burst_tracker (
        .clk        (iHCLK),
        .rst_n      (iHRESETn),
        .accept     (iHREADY),
        .err_first  (err_first),
        .htrans     (own_htrans),
        .hburst     (own_hburst),
        .hbusreq    (own_hbusreq),
        .lock_after (lock_after)
    );

    always_ff @(posedge iHCLK or negedge iHRESETn) begin
        if (!iHRESETn) begin
            state_q      <= DEF_STATE;
            owner_q      <= DEF_MST;
            data_owner_q <= DEF_MST;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            data_owner_q <= data_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        data_owner_d = data_owner_q;
        cur          = (state_q == OWN1);
        req_cur      = cur ? iM1_HBUSREQ : iM0_HBUSREQ;
        req_oth      = cur ? iM0_HBUSREQ : iM1_HBUSREQ;
        if (iHREADY) begin
            owner_d      = cur;
            data_owner_d = owner_q;
            // With two masters the grantee is always the last one granted, so a requesting peer wins
            if (!lock_after) begin
                if (req_oth)       state_d = arb_state_e'(!cur);
                else if (!req_cur) state_d = DEF_STATE;
            end
        end
    end

    always_comb begin
        oM0_HGRANT = (state_q == OWN0);
        oM1_HGRANT = (state_q == OWN1);
        oHMASTER   = owner_q;
        oHREADY    = iHREADY;
        if (owner_q) begin
            oHADDR  = iM1_HADDR;
            oHTRANS = iM1_HTRANS;
            oHWRITE = iM1_HWRITE;
            oHSIZE  = iM1_HSIZE;
            oHBURST = iM1_HBURST;
        end else begin
            oHADDR  = iM0_HADDR;
            oHTRANS = iM0_HTRANS;
            oHWRITE = iM0_HWRITE;
            oHSIZE  = iM0_HSIZE;
            oHBURST = iM0_HBURST;
        end
        oHWDATA = data_owner_q ? iM1_HWDATA : iM0_HWDATA;
    end

endmodule
